req_sched: RTL and testbench
============================

# req_sched

Round-robin scheduler that shares the single traffic-control FSM command port among up to four requesters (gate 1, gate 2, auxiliary, pedestrian). It sits between the `ui_in` request sources and the FSM. It grants one requester at a time, forwards that requester's 2-bit command to the FSM, and holds the grant until release. Hold time is bounded by an optional watchdog.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `MAX_HOLD`, 15: maximum cycles in HOLD before forced release (1..255).

Ports:
- `clk`: in, 1, single clock. All logic is on the rising edge.
- `reset`: in, 1, synchronous, active-high.
- `req`: in, N_REQ, request level, one bit per requester.
- `rel`: in, N_REQ, release pulse, one bit per requester.
- `cmd_in`: in, 2*N_REQ, 2-bit command per requester. Requester i uses bits [2i+1:2i].
- `gnt`: out, N_REQ, one-hot grant; all zero when no owner.
- `gnt_id`: out, $clog2(N_REQ), index of the current owner; 0 when idle.
- `cmd_out`: out, 2, command captured from the owner.
- `cmd_valid`: out, 1, one-cycle strobe; the FSM samples `cmd_out` on it.
- `busy`: out, 1, high in GRANT and HOLD.
- `timeout`: out, 1, one-cycle pulse on forced release.

## Operation
- States: IDLE, GRANT, HOLD, GAP.
- IDLE:
  - If any `req` bit is high, pick the winner round-robin. Search starts at `last_id+1` and wraps modulo N_REQ.
  - On the same edge, register `gnt`, `gnt_id`, `cmd_out <= cmd_in[winner]` and `last_id <= winner`, then go to GRANT.
  - If no `req` bit is high, stay in IDLE.
- GRANT: lasts exactly 1 cycle. `cmd_valid`=1, `busy`=1. Go to HOLD and clear the hold counter.
- HOLD:
  - `gnt` and `cmd_out` stay stable. The hold counter increments and saturates at MAX_HOLD.
  - Exit to GAP on `rel[owner]` or `!req[owner]`.
  - With the watchdog compiled in, also exit to GAP when the counter equals MAX_HOLD.
- GAP: lasts exactly 1 cycle. `gnt`=0, `cmd_out`=0, `busy`=0. Go to IDLE. This guarantees at least one dead cycle between owners.
- Release and withdrawal:
  - `rel` bits of non-owners are ignored.
  - `req` dropping during GRANT is treated as a release on the next HOLD cycle.
- Simultaneous events: if release and watchdog expiry occur in the same cycle, release wins and `timeout` stays 0.
- Command rules: `cmd_in` changes during HOLD are not forwarded. Each command is issued once per grant.
- Reset values:
  - All outputs are 0. State is IDLE and the counter is 0.
  - `last_id` = N_REQ-1, so requester 0 has first priority.
- Reset mid-operation: on the next edge, every output and state reverts to its reset value. No `cmd_valid` or `timeout` pulse is emitted.

## Timing
- `req` high at edge t in IDLE → `gnt` and `cmd_valid` high after edge t+1.
- `cmd_valid` is high for exactly one cycle per grant.
- `rel` at edge t in HOLD → `gnt`=0 after edge t+1 (GAP). The next grant appears after edge t+3 at the earliest.
- Fairness: with all requesters active continuously, grants rotate 0,1,2,…,N_REQ-1,0. Each requester is served within N_REQ grant slots.
- Watchdog bound: HOLD lasts at most MAX_HOLD+1 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `REQ_SCHED_TIMEOUT_EN`.
- Defined:
  - The hold counter is built.
  - Reaching MAX_HOLD in HOLD forces a move to GAP and pulses `timeout` for 1 cycle, coincident with `gnt` going low.
- Undefined:
  - No counter is built and `timeout` is tied to 0.
  - HOLD ends only on release or request withdrawal.
  - `MAX_HOLD` is ignored.

## Structure
- Package `req_sched_pkg`:
  - `sched_state_t` enum {IDLE, GRANT, HOLD, GAP}.
  - `CMD_W`=2.
  - Default constants for N_REQ and MAX_HOLD.
- Sub-module `rr_picker`: combinational rotate-and-priority-encode. Inputs: `req` and `last_id`. Outputs: `winner` and `any`. It is instantiated once.

## Test plan
- Reset then single request: reset 2 cycles; `req`=4'b0100 with `cmd_in[5:4]`=2'b10 → after 1 edge `gnt`=4'b0100, `gnt_id`=2, `cmd_out`=2'b10, `cmd_valid`=1 for 1 cycle.
- Round-robin rotation: `req`=4'b1111 held, each owner pulses `rel` 2 cycles after grant → grant order 0,1,2,3,0 with one GAP cycle (`gnt`=0) between each.
- Watchdog, defined: owner 1 holds `req` high with no `rel`, MAX_HOLD=15 → `timeout` pulses once, HOLD lasts 16 cycles, then `gnt`=0; the next grant goes to requester 2 if it is requesting.
- Watchdog, undefined: same stimulus for 100 cycles → `gnt` stays 4'b0010 and `timeout` is always 0.
- Stray release and withdrawal: owner 0 in HOLD; `rel`=4'b0010 → no change; then `req[0]` drops → GAP on the next edge.
- Reset mid-HOLD: assert `reset` while owner 3 holds → after 1 edge all outputs are 0; after deassert with `req`=4'b1001, requester 0 is granted first.

Source files
------------

// File: rtl/req_sched_pkg.sv
// Shared types and defaults for the req_sched round-robin command scheduler.
package req_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } sched_state_t;

    localparam int CMD_W        = 2;
    localparam int DEF_N_REQ    = 4;
    localparam int DEF_MAX_HOLD = 15;
    // Wide enough for the largest allowed MAX_HOLD (255).
    localparam int HOLD_W       = 8;

endpackage

// File: rtl/req_sched_rr_picker.sv
// Combinational round-robin picker: rotates the search to start just after
// last_id and returns the first requesting index, wrapping modulo N_REQ.
module rr_picker
    import req_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_id,
    output logic [$clog2(N_REQ)-1:0] winner,
    output logic                     any
);

    localparam int IDW = $clog2(N_REQ);

    logic [IDW:0] idx;

    // Walk the search order backwards so the nearest candidate is written last.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = {1'b0, last_id} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(N_REQ)) begin
                idx = idx - (IDW+1)'(N_REQ);
            end
            if (req[idx[IDW-1:0]]) begin
                winner = idx[IDW-1:0];
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_sched.sv
// Round-robin scheduler sharing one FSM command port among N_REQ requesters.
// Optional hold watchdog is compiled in with REQ_SCHED_TIMEOUT_EN.
module req_sched
    import req_sched_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           rel,
    input  logic [CMD_W*N_REQ-1:0]     cmd_in,
    output logic [N_REQ-1:0]           gnt,
    output logic [$clog2(N_REQ)-1:0]   gnt_id,
    output logic [CMD_W-1:0]           cmd_out,
    output logic                       cmd_valid,
    output logic                       busy,
    output logic                       timeout,
    output logic [1:0]                 state_dbg
);

    localparam int ID_W = $clog2(N_REQ);

    // cmd_valid is a one-cycle strobe with no ready: the FSM must take cmd_out
    // in the cycle cmd_valid is high; gnt then holds until release/withdrawal.
    sched_state_t     state;
    logic [ID_W-1:0]  last_id;
    logic [ID_W-1:0]  winner;
    logic             any_req;
    logic [CMD_W-1:0] cmd_arr [N_REQ];
    logic             owner_done;
    logic             wd_expire;

    for (genvar i = 0; i < N_REQ; i++) begin : g_cmd
        assign cmd_arr[i] = cmd_in[CMD_W*i +: CMD_W];
    end

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req     (req),
        .last_id (last_id),
        .winner  (winner),
        .any     (any_req)
    );

    // Release bits of non-owners never reach this term.
    assign owner_done = rel[gnt_id] | ~req[gnt_id];
    assign state_dbg  = state;

`ifdef REQ_SCHED_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] hold_cnt;

    assign wd_expire = (hold_cnt == HOLD_LIMIT);
`else
    logic unused_max_hold;

    assign unused_max_hold = ^MAX_HOLD;
    assign wd_expire       = 1'b0;
    assign timeout         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            cmd_out   <= '0;
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
            last_id   <= ID_W'(N_REQ-1);
`ifdef REQ_SCHED_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            cmd_valid <= 1'b0;
`ifdef REQ_SCHED_TIMEOUT_EN
            timeout   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= GRANT;
                        gnt       <= {{(N_REQ-1){1'b0}}, 1'b1} << winner;
                        gnt_id    <= winner;
                        cmd_out   <= cmd_arr[winner];
                        last_id   <= winner;
                        cmd_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                GRANT: begin
                    state <= HOLD;
`ifdef REQ_SCHED_TIMEOUT_EN
                    hold_cnt <= '0;
`endif
                end
                HOLD: begin
                    // A real release takes priority over watchdog expiry.
                    if (owner_done || wd_expire) begin
                        state   <= GAP;
                        gnt     <= '0;
                        gnt_id  <= '0;
                        cmd_out <= '0;
                        busy    <= 1'b0;
                    end
`ifdef REQ_SCHED_TIMEOUT_EN
                    timeout <= wd_expire & ~owner_done;
                    if (!wd_expire) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
`endif
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_sched.sv
// Directed self-checking bench for req_sched (N_REQ=4, MAX_HOLD=15).
module tb_req_sched;
    import req_sched_pkg::*;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] rel;
    logic [7:0] cmd_in;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic [1:0] cmd_out;
    logic       cmd_valid;
    logic       busy;
    logic       timeout;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] exp_q[$];

    req_sched #(.N_REQ(4), .MAX_HOLD(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .rel       (rel),
        .cmd_in    (cmd_in),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .cmd_out   (cmd_out),
        .cmd_valid (cmd_valid),
        .busy      (busy),
        .timeout   (timeout),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "bench time limit reached");
    end

    // drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        rel   = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({gnt, gnt_id, cmd_out, cmd_valid, busy, timeout} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b id=%0d cmd=%b v=%b busy=%b to=%b, required all 0",
                     gnt, gnt_id, cmd_out, cmd_valid, busy, timeout);
        end
        n_checks++;
        if (state_dbg !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, required %0d", state_dbg, IDLE);
        end
    endtask

    task automatic test_single();
        do_reset();
        req    = 4'b0100;
        cmd_in = 8'b00_10_00_00;
        step();
        n_checks++;
        if ({gnt, gnt_id, cmd_out, cmd_valid, busy} !== {4'b0100, 2'd2, 2'b10, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL single_grant: got gnt=%b id=%0d cmd=%b v=%b busy=%b, required 0100 2 10 1 1",
                     gnt, gnt_id, cmd_out, cmd_valid, busy);
        end
        step();
        n_checks++;
        if ({gnt, cmd_out, cmd_valid, busy} !== {4'b0100, 2'b10, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL single_hold: got gnt=%b cmd=%b v=%b busy=%b, required 0100 10 0 1",
                     gnt, cmd_out, cmd_valid, busy);
        end
        cmd_in = 8'b00_01_00_00;
        step();
        n_checks++;
        if (cmd_out !== 2'b10 || cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_cmd_frozen: got cmd=%b v=%b, required 10 0", cmd_out, cmd_valid);
        end
        rel = 4'b0100;
        step();
        rel = 4'b0000;
        req = 4'b0000;
        n_checks++;
        if ({gnt, gnt_id, cmd_out, busy, timeout} !== 10'd0 || state_dbg !== GAP) begin
            n_fail++;
            $display("FAIL release_gap: got gnt=%b id=%0d cmd=%b busy=%b to=%b st=%0d, required 0 0 0 0 0 st=3",
                     gnt, gnt_id, cmd_out, busy, timeout, state_dbg);
        end
        step();
    endtask

    task automatic test_rotation();
        logic [1:0] exp_id;
        int n;
        do_reset();
        req    = 4'b1111;
        cmd_in = 8'b11_10_01_00;
        exp_q  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        while (exp_q.size() > 0) begin
            exp_id = exp_q.pop_front();
            n = 0;
            while (gnt == 4'b0000 && n < 6) begin
                step();
                n++;
            end
            n_checks++;
            if ({gnt, gnt_id, cmd_out, cmd_valid} !== {4'b0001 << exp_id, exp_id, exp_id, 1'b1}) begin
                n_fail++;
                $display("FAIL rr_grant: got gnt=%b id=%0d cmd=%b v=%b, required gnt=%b id=%0d cmd=%b v=1",
                         gnt, gnt_id, cmd_out, cmd_valid, 4'b0001 << exp_id, exp_id, exp_id);
            end
            step();
            rel = 4'b0001 << exp_id;
            step();
            rel = 4'b0000;
            n_checks++;
            if (gnt !== 4'b0000 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_gap: got gnt=%b busy=%b, required 0000 0", gnt, busy);
            end
        end
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_watchdog();
        int n;
        do_reset();
`ifdef REQ_SCHED_TIMEOUT_EN
        req    = 4'b0110;
        cmd_in = 8'b00_00_11_00;
        step();
        n_checks++;
        if (gnt !== 4'b0010 || cmd_out !== 2'b11) begin
            n_fail++;
            $display("FAIL wd_grant: got gnt=%b cmd=%b, required 0010 11", gnt, cmd_out);
        end
        step();
        n = 0;
        while (gnt == 4'b0010 && n < 40) begin
            n++;
            n_checks++;
            if (timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL wd_early_timeout: got %b during hold cycle %0d, required 0", timeout, n);
            end
            step();
        end
        n_checks++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL wd_hold_len: got %0d cycles, required 16", n);
        end
        n_checks++;
        if (timeout !== 1'b1 || gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL wd_pulse: got to=%b gnt=%b, required 1 0000", timeout, gnt);
        end
        step();
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_pulse_width: got %b, required 0", timeout);
        end
        step();
        n_checks++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
            n_fail++;
            $display("FAIL wd_next_owner: got gnt=%b id=%0d, required 0100 2", gnt, gnt_id);
        end
`else
        req    = 4'b0010;
        cmd_in = 8'b00_00_11_00;
        step();
        for (int c = 0; c < 100; c++) begin
            step();
            n_checks++;
            if (gnt !== 4'b0010 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL nowd_hold: cycle %0d got gnt=%b to=%b, required 0010 0", c, gnt, timeout);
            end
        end
`endif
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_stray_release();
        do_reset();
        req    = 4'b0001;
        cmd_in = 8'b00_00_00_01;
        step();
        step();
        rel = 4'b0010;
        step();
        rel = 4'b0000;
        n_checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1 || state_dbg !== HOLD) begin
            n_fail++;
            $display("FAIL stray_rel: got gnt=%b busy=%b st=%0d, required 0001 1 st=2", gnt, busy, state_dbg);
        end
        req = 4'b0000;
        step();
        n_checks++;
        if (gnt !== 4'b0000 || state_dbg !== GAP || cmd_out !== 2'b00) begin
            n_fail++;
            $display("FAIL withdraw_gap: got gnt=%b st=%0d cmd=%b, required 0000 st=3 00", gnt, state_dbg, cmd_out);
        end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req    = 4'b1000;
        cmd_in = 8'b10_00_00_00;
        step();
        n_checks++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            n_fail++;
            $display("FAIL mid_grant: got gnt=%b id=%0d, required 1000 3", gnt, gnt_id);
        end
        step();
        step();
        reset = 1'b1;
        req   = 4'b1001;
        step();
        n_checks++;
        if ({gnt, gnt_id, cmd_out, cmd_valid, busy, timeout} !== 13'd0 || state_dbg !== IDLE) begin
            n_fail++;
            $display("FAIL mid_reset: got gnt=%b id=%0d cmd=%b v=%b busy=%b to=%b st=%0d, required all 0",
                     gnt, gnt_id, cmd_out, cmd_valid, busy, timeout, state_dbg);
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0 || cmd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_prio: got gnt=%b id=%0d v=%b, required 0001 0 1", gnt, gnt_id, cmd_valid);
        end
        req = 4'b0000;
        step();
        step();
    endtask

    // sequence and final report
    initial begin
        reset  = 1'b1;
        req    = '0;
        rel    = '0;
        cmd_in = '0;
        test_reset();
        test_single();
        test_rotation();
        test_watchdog();
        test_stray_release();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
